// File: rtl/fifo_bit_reader.sv
// Read-side consumer for a 1-bit FIFO. It packs WIDTH serial bits into a word.
// Finished words are held in an output register so collection of the next word can proceed.
module fifo_bit_reader #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             r_clk,
  input  logic             rst,
  input  logic             empty,
  input  logic             dataout,
  output logic             r_en,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [15:0]      word_cnt
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] sh_q, sh_d, word_q, word_d, cap_word_s;
  logic [CW-1:0]    iss_q, iss_d, cap_q, cap_d, pos_s;
  logic             pend_q, pend_d, valid_q, valid_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             last_s, accept_s, complete_s, stall_s, capture_s;

  // Issuing stops once a whole word has been requested; only empty, iss and rst matter.
  assign r_en       = rst && !empty && (iss_q != CNT_FULL);
  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign word_cnt   = cnt_q;

  // Decode capture, completion and stall conditions for this edge
  always_comb begin
    last_s     = pend_q && (cap_q == CNT_LAST);
    accept_s   = valid_q && word_ready;
    complete_s = last_s && (!valid_q || word_ready);
    stall_s    = last_s && !complete_s;
    capture_s  = pend_q && !stall_s;
    if (MSB_FIRST) begin
      pos_s = CNT_LAST - cap_q;
    end else begin
      pos_s = cap_q;
    end
  end

  // Shift register contents with the incoming bit dropped into its slot
  always_comb begin
    cap_word_s = sh_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (CW'(i) == pos_s) begin
        cap_word_s[i] = dataout;
      end else begin
        cap_word_s[i] = sh_q[i];
      end
    end
  end

  // Next-state logic for counters, shift register and output slot
  always_comb begin
    sh_d    = sh_q;
    iss_d   = iss_q;
    cap_d   = cap_q;
    word_d  = word_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    // A stalled last bit stays pending so dataout is re-sampled next edge.
    pend_d  = r_en || stall_s;

    if (r_en) begin
      iss_d = iss_q + CNT_ONE;
    end else begin
      iss_d = iss_q;
    end

    if (capture_s) begin
      sh_d  = cap_word_s;
      cap_d = cap_q + CNT_ONE;
    end else begin
      sh_d  = sh_q;
      cap_d = cap_q;
    end

    if (complete_s) begin
      iss_d   = CNT_ZERO;
      cap_d   = CNT_ZERO;
      word_d  = cap_word_s;
      valid_d = 1'b1;
    end else if (accept_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    if (accept_s) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge r_clk or negedge rst) begin
    if (!rst) begin
      sh_q    <= {WIDTH{1'b0}};
      iss_q   <= CNT_ZERO;
      cap_q   <= CNT_ZERO;
      pend_q  <= 1'b0;
      word_q  <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      sh_q    <= sh_d;
      iss_q   <= iss_d;
      cap_q   <= cap_d;
      pend_q  <= pend_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_bit_reader.sv
// Bench for fifo_bit_reader: a queue-based FIFO model feeds the DUT, and a count-level
// reference predicts r_en, word_valid, word_out and word_cnt on every cycle.
module tb_fifo_bit_reader;
  localparam int W   = 8;
  localparam bit MSB = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, empty = 1'b1, dataout = 1'b0, word_ready = 1'b0;
  logic          r_en, word_valid;
  logic [W-1:0]  word_out;
  logic [15:0]   word_cnt;

  fifo_bit_reader #(.WIDTH(W), .MSB_FIRST(MSB)) dut (
    .r_clk(clk), .rst(rst), .empty(empty), .dataout(dataout), .r_en(r_en),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready), .word_cnt(word_cnt));

  // Side instances for LSB-first and 4-bit words, fed from fixed preloads.
  logic        empty1 = 1'b0, dout1 = 1'b0, ren1, vld1;
  logic [7:0]  wout1;
  logic [15:0] cnt1;
  logic        empty2 = 1'b0, dout2 = 1'b0, ren2, vld2;
  logic [3:0]  wout2;
  logic [15:0] cnt2;

  fifo_bit_reader #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .r_clk(clk), .rst(rst), .empty(empty1), .dataout(dout1), .r_en(ren1),
    .word_out(wout1), .word_valid(vld1), .word_ready(1'b1), .word_cnt(cnt1));

  fifo_bit_reader #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_w4 (
    .r_clk(clk), .rst(rst), .empty(empty2), .dataout(dout2), .r_en(ren2),
    .word_out(wout2), .word_valid(vld2), .word_ready(1'b1), .word_cnt(cnt2));

  int n_checks = 0;
  int n_errors = 0;

  bit          fq[$];
  bit          rd_bits[$];
  logic [7:0]  acc_log[$];
  logic [7:0]  log1[$];
  logic [3:0]  log2[$];
  int          gate_mode = 0;
  int          ready_mode = 0;
  bit          gate = 1'b0;

  int          m_reads = 0;
  int          m_words = 0;
  bit          m_valid = 1'b0;
  logic [W-1:0] m_wout = '0;
  logic [15:0] m_cnt = 16'd0;

  bit s_ren, s_empty, s_ready, s_rst, acc, comp, b, exp_ren;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack_word(input int k);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (MSB) w[W-1-i] = rd_bits[k*W+i];
      else     w[i]     = rd_bits[k*W+i];
    end
    return w;
  endfunction

  task automatic model_reset();
    m_reads = 0;
    m_words = 0;
    m_valid = 1'b0;
    m_wout  = '0;
    m_cnt   = 16'd0;
    rd_bits.delete();
  endtask

  task automatic push_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) fq.push_back(w[i]);
  endtask

  // Compare at the falling edge, then advance FIFO and model just after the rising edge.
  always begin
    @(negedge clk);
    if (!rst) model_reset();
    exp_ren = rst && !empty && (m_reads < W * (m_words + 1));
    chk("r_en", 32'(r_en), 32'(exp_ren));
    chk("word_valid", 32'(word_valid), 32'(m_valid));
    chk("word_out", 32'(word_out), 32'(m_wout));
    chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
    s_ren = r_en; s_empty = empty; s_ready = word_ready; s_rst = rst;
    if (rst && word_valid && word_ready) acc_log.push_back(word_out);
    @(posedge clk);
    #1;
    if (!s_rst || !rst) begin
      model_reset();
    end else begin
      acc  = m_valid && s_ready;
      comp = (m_reads == W * (m_words + 1)) && (!m_valid || s_ready);
      if (acc) m_cnt = m_cnt + 16'd1;
      if (comp) begin
        m_wout  = pack_word(m_words);
        m_words = m_words + 1;
        m_valid = 1'b1;
      end else if (acc) begin
        m_valid = 1'b0;
      end
      if (s_ren && !s_empty && fq.size() > 0) begin
        b = fq.pop_front();
        dataout = b;
        rd_bits.push_back(b);
        m_reads = m_reads + 1;
      end
    end
    case (gate_mode)
      1:       gate = !gate;
      2:       gate = ($urandom_range(0, 3) == 0);
      default: gate = 1'b0;
    endcase
    case (ready_mode)
      1:       word_ready = 1'b1;
      2:       word_ready = ($urandom_range(0, 2) != 0);
      default: word_ready = 1'b0;
    endcase
    empty = (fq.size() == 0) || gate;
  end

  // Preloaded FIFOs for the side instances: 1,0,1,0,1,0,1,0
  bit pre8 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  int idx1 = 0, idx2 = 0;
  bit s1, s2;
  always begin
    @(negedge clk);
    s1 = ren1 && !empty1;
    s2 = ren2 && !empty2;
    if (rst && vld1) log1.push_back(wout1);
    if (rst && vld2) log2.push_back(wout2);
    @(posedge clk);
    #1;
    if (s1 && idx1 < 8) begin dout1 = pre8[idx1]; idx1++; end
    if (s2 && idx2 < 8) begin dout2 = pre8[idx2]; idx2++; end
    empty1 = (idx1 >= 8);
    empty2 = (idx2 >= 8);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base;
  initial begin
    #1 rst = 1'b0;
    #1;
    chk("rst_r_en", 32'(r_en), 32'd0);
    chk("rst_word_out", 32'(word_out), 32'd0);
    chk("rst_word_valid", 32'(word_valid), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // Single word 0xAA with ready held high
    ready_mode = 1;
    push_word(8'hAA);
    for (int i = 0; i < 60 && acc_log.size() < 1; i++) @(negedge clk);
    chk("aa_count", 32'(acc_log.size()), 32'd1);
    chk("aa_word", 32'(acc_log[0]), 32'h0000_00AA);
    repeat (3) @(negedge clk);
    chk("aa_cnt", 32'(word_cnt), 32'd1);
    chk("aa_idle_ren", 32'(r_en), 32'd0);

    // Side instances have long since drained their preloads
    chk("lsb_count", 32'(log1.size()), 32'd1);
    chk("lsb_word", 32'(log1[0]), 32'h0000_0055);
    chk("lsb_cnt", 32'(cnt1), 32'd1);
    chk("w4_count", 32'(log2.size()), 32'd2);
    chk("w4_word0", 32'(log2[0]), 32'h0000_000A);
    chk("w4_word1", 32'(log2[1]), 32'h0000_000A);
    chk("w4_cnt", 32'(cnt2), 32'd2);
    chk("lsb_idle_ren", 32'(ren1), 32'd0);

    // Back-pressure: 24 ones with ready low, then release
    ready_mode = 0;
    push_word(8'hFF); push_word(8'hFF); push_word(8'hFF);
    repeat (40) @(negedge clk);
    chk("bp_valid", 32'(word_valid), 32'd1);
    chk("bp_word", 32'(word_out), 32'h0000_00FF);
    chk("bp_ren", 32'(r_en), 32'd0);
    chk("bp_fifo_left", 32'(fq.size()), 32'd8);
    ready_mode = 1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("bp_same_edge_valid", 32'(word_valid), 32'd1);
    chk("bp_same_edge_cnt", 32'(word_cnt), 32'd2);
    for (int i = 0; i < 80 && acc_log.size() < 4; i++) @(negedge clk);
    chk("bp_count", 32'(acc_log.size()), 32'd4);
    for (int k = 1; k < 4; k++) chk("bp_words", 32'(acc_log[k]), 32'h0000_00FF);

    // empty toggling every cycle during 1,0,1,1,0,0,1,0
    gate_mode = 1;
    push_word(8'hB2);
    for (int i = 0; i < 80 && acc_log.size() < 5; i++) @(negedge clk);
    chk("gap_count", 32'(acc_log.size()), 32'd5);
    chk("gap_word", 32'(acc_log[4]), 32'h0000_00B2);
    gate_mode = 0;

    // Reset in the middle of a word
    push_word(8'h5A);
    for (int i = 0; i < 40 && fq.size() > 3; i++) @(negedge clk);
    chk("partial_read", 32'(fq.size() <= 3), 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_r_en", 32'(r_en), 32'd0);
    chk("mid_rst_word_out", 32'(word_out), 32'd0);
    chk("mid_rst_word_valid", 32'(word_valid), 32'd0);
    chk("mid_rst_word_cnt", 32'(word_cnt), 32'd0);
    fq.delete();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    base = acc_log.size();
    push_word(8'hC3);
    for (int i = 0; i < 60 && acc_log.size() < base + 1; i++) @(negedge clk);
    chk("post_rst_count", 32'(acc_log.size() - base), 32'd1);
    chk("post_rst_word", 32'(acc_log[base]), 32'h0000_00C3);
    @(negedge clk);
    chk("post_rst_cnt", 32'(word_cnt), 32'd1);

    // Randomised traffic: random empty gaps and random back-pressure
    base = acc_log.size();
    gate_mode = 2;
    ready_mode = 2;
    for (int k = 0; k < 50; k++) push_word(8'($urandom_range(0, 255)));
    for (int i = 0; i < 4000 && fq.size() > 0; i++) @(negedge clk);
    chk("rand_fifo_drained", 32'(fq.size()), 32'd0);
    gate_mode = 0;
    ready_mode = 1;
    repeat (30) @(negedge clk);
    chk("rand_count", 32'(acc_log.size() - base), 32'd50);
    chk("rand_final_valid", 32'(word_valid), 32'd0);
    chk("rand_final_cnt", 32'(word_cnt), 32'd51);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
